// File: rtl/reg_dump_reader_pkg.sv
// ============================================================================
// Module      : reg_dump_reader_pkg
// Description : Shared widths and state encoding for the register-file dump
//               reader, reusable by the core top level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_dump_reader_pkg;

    localparam int C_DATA_W = 16;
    localparam int C_ADDR_W = 4;
    localparam int C_NREGS  = 1 << C_ADDR_W;

    localparam logic [2:0] C_ST_IDLE   = 3'd0;
    localparam logic [2:0] C_ST_READ   = 3'd1;
    localparam logic [2:0] C_ST_SEND_A = 3'd2;
    localparam logic [2:0] C_ST_SEND_B = 3'd3;
    localparam logic [2:0] C_ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = C_ST_IDLE,
        ST_READ   = C_ST_READ,
        ST_SEND_A = C_ST_SEND_A,
        ST_SEND_B = C_ST_SEND_B,
        ST_DONE   = C_ST_DONE
    } state_t;

endpackage

`default_nettype wire

// File: rtl/reg_dump_reader.sv
// ============================================================================
// Module      : reg_dump_reader
// Description : Walks an inclusive register range two registers per read and
//               streams each word out on a valid/ready port tagged by address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int ADDR_W = C_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              done,
    output logic              core_hold,
    output logic [ADDR_W-1:0] rf_rs,
    output logic [ADDR_W-1:0] rf_rt,
    input  logic [DATA_W-1:0] rf_rout1,
    input  logic [DATA_W-1:0] rf_rout2,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam int CNT_W = ADDR_W + 1;

    state_t              state_q,     state_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic [DATA_W-1:0]   buf_a_q,     buf_a_d;
    logic [DATA_W-1:0]   buf_b_q,     buf_b_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                m_valid_q,   m_valid_d;
    logic                m_last_q,    m_last_d;
    logic [ADDR_W-1:0]   rf_rs_q,     rf_rs_d;
    logic [ADDR_W-1:0]   rf_rt_q,     rf_rt_d;
    logic [DATA_W-1:0]   m_data_q,    m_data_d;
    logic [ADDR_W-1:0]   m_addr_q,    m_addr_d;
    logic                w_accept;
    logic                w_last_word;

    assign w_accept    = m_valid_q && m_ready;
    assign w_last_word = (remaining_q == CNT_W'(1));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        buf_a_d     = buf_a_q;
        buf_b_d     = buf_b_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d      = first_addr;
                    // The ADDR_W-wide difference wraps, so reversed ranges run through the top.
                    remaining_d = {1'b0, last_addr - first_addr} + CNT_W'(1);
                    state_d     = ST_READ;
                end
            end
            ST_READ: begin
                buf_a_d = rf_rout1;
                buf_b_d = rf_rout2;
                state_d = ST_SEND_A;
            end
            ST_SEND_A: begin
                if (w_accept) begin
                    if (w_last_word) begin
                        state_d = ST_DONE;
                    end else begin
                        remaining_d = remaining_q - CNT_W'(1);
                        state_d     = ST_SEND_B;
                    end
                end
            end
            ST_SEND_B: begin
                if (w_accept) begin
                    if (w_last_word) begin
                        state_d = ST_DONE;
                    end else begin
                        remaining_d = remaining_q - CNT_W'(1);
                        addr_d      = addr_q + ADDR_W'(2);
                        state_d     = ST_READ;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        m_valid_d = (state_d == ST_SEND_A) || (state_d == ST_SEND_B);
        m_last_d  = m_valid_d && (remaining_d == CNT_W'(1));
        rf_rs_d   = '0;
        rf_rt_d   = '0;
        m_data_d  = '0;
        m_addr_d  = '0;
        if (state_d == ST_READ) begin
            rf_rs_d = addr_d;
            rf_rt_d = addr_d + ADDR_W'(1);
        end
        if (state_d == ST_SEND_A) begin
            m_data_d = buf_a_d;
            m_addr_d = addr_d;
        end else if (state_d == ST_SEND_B) begin
            m_data_d = buf_b_d;
            m_addr_d = addr_d + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            buf_a_q     <= '0;
            buf_b_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            rf_rs_q     <= '0;
            rf_rt_q     <= '0;
            m_data_q    <= '0;
            m_addr_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            buf_a_q     <= buf_a_d;
            buf_b_q     <= buf_b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            rf_rs_q     <= rf_rs_d;
            rf_rt_q     <= rf_rt_d;
            m_data_q    <= m_data_d;
            m_addr_q    <= m_addr_d;
        end
    end

    assign busy      = busy_q;
    assign core_hold = busy_q;
    assign done      = done_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign rf_rs     = rf_rs_q;
    assign rf_rt     = rf_rt_q;
    assign m_data    = m_data_q;
    assign m_addr    = m_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
// ============================================================================
// Module      : tb_reg_dump_reader
// Description : Directed self-checking bench for reg_dump_reader with a
//               combinational register-file model (Rn = n replicated).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_dump_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  first_addr = '0;
    logic [3:0]  last_addr = '0;
    logic        busy, done, core_hold;
    logic [3:0]  rf_rs, rf_rt;
    logic [15:0] rf_rout1, rf_rout2;
    logic [15:0] m_data;
    logic [3:0]  m_addr;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rf_rout1 = {4{rf_rs}};
    assign rf_rout2 = {4{rf_rt}};

    reg_dump_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .busy       (busy),
        .done       (done),
        .core_hold  (core_hold),
        .rf_rs      (rf_rs),
        .rf_rt      (rf_rt),
        .rf_rout1   (rf_rout1),
        .rf_rout2   (rf_rout2),
        .m_data     (m_data),
        .m_addr     (m_addr),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Runs one dump from IDLE. mode 0: m_ready always high; mode 1: 1,0,0,1 pattern.
    // restart_cyc > 0 pulses start with a different range at that cycle.
    task automatic run_dump(input logic [3:0] f, input logic [3:0] l, input int mode,
                            input int restart_cyc, input int exp_done_cyc, input string tag);
        int          n;
        int          k;
        int          cyc;
        bit          got_done;
        bit          held;
        logic [15:0] held_data;
        logic [3:0]  held_addr;
        logic        held_last;
        logic [3:0]  exp_addr;
        n = int'(4'(l - f)) + 1;
        k = 0;
        cyc = 1;
        got_done = 0;
        held = 0;
        held_data = '0;
        held_addr = '0;
        held_last = 1'b0;
        first_addr = f;
        last_addr  = l;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || core_hold !== 1'b1 || m_valid !== 1'b0 || rf_rs !== f || rf_rt !== 4'(f + 1)) begin
            errors++;
            $display("FAIL %s first_read: busy=%b hold=%b valid=%b rs=%h rt=%h required busy=1 hold=1 valid=0 rs=%h rt=%h",
                     tag, busy, core_hold, m_valid, rf_rs, rf_rt, f, 4'(f + 1));
        end
        while (!got_done && cyc < 300) begin
            m_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (held) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== held_data || m_addr !== held_addr || m_last !== held_last) begin
                    errors++;
                    $display("FAIL %s stall_stable cyc=%0d: valid=%b data=%h addr=%h last=%b required valid=1 data=%h addr=%h last=%b",
                             tag, cyc, m_valid, m_data, m_addr, m_last, held_data, held_addr, held_last);
                end
            end
            held = 0;
            if (m_valid === 1'b1) begin
                if (m_ready) begin
                    exp_addr = 4'(f + 4'(k));
                    checks++;
                    if (k >= n || m_addr !== exp_addr || m_data !== {4{exp_addr}} || m_last !== (k == n - 1)) begin
                        errors++;
                        $display("FAIL %s word%0d: addr=%h data=%h last=%b required addr=%h data=%h last=%b (count %0d)",
                                 tag, k, m_addr, m_data, m_last, exp_addr, {4{exp_addr}}, (k == n - 1), n);
                    end
                    k++;
                end else begin
                    held = 1;
                    held_data = m_data;
                    held_addr = m_addr;
                    held_last = m_last;
                end
            end
            if (done === 1'b1) begin
                got_done = 1;
            end else begin
                if (cyc == restart_cyc) begin
                    first_addr = 4'h8;
                    last_addr  = 4'h8;
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                step();
                cyc++;
            end
        end
        start = 1'b0;
        m_ready = 1'b0;
        checks++;
        if (!got_done || k != n) begin
            errors++;
            $display("FAIL %s completion: done_seen=%0d words=%0d required done_seen=1 words=%0d", tag, got_done, k, n);
        end
        if (exp_done_cyc > 0) begin
            checks++;
            if (cyc != exp_done_cyc) begin
                errors++;
                $display("FAIL %s done_cycle: got %0d required %0d", tag, cyc, exp_done_cyc);
            end
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b valid=%b required 0 0 0", tag, done, busy, m_valid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b1;
        step();
        step();
        checks++;
        if ({busy, done, core_hold, m_valid, m_last} !== 5'b0 || rf_rs !== 4'h0 || rf_rt !== 4'h0
            || m_data !== 16'h0 || m_addr !== 4'h0) begin
            errors++;
            $display("FAIL reset_values: ctl=%b rs=%h rt=%h data=%h addr=%h required all zero",
                     {busy, done, core_hold, m_valid, m_last}, rf_rs, rf_rt, m_data, m_addr);
        end
        start = 1'b0;
        rst = 1'b0;
        m_ready = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL ready_idle: busy=%b valid=%b required 0 0", busy, m_valid);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_full_range;
        run_dump(4'h0, 4'hF, 0, 0, 25, "full");
    endtask

    task automatic test_single;
        run_dump(4'h3, 4'h3, 0, 0, 3, "single");
    endtask

    task automatic test_wrap;
        run_dump(4'hE, 4'h1, 0, 0, 7, "wrap");
    endtask

    task automatic test_backpressure;
        run_dump(4'h0, 4'hF, 1, 0, 0, "stall");
    endtask

    task automatic test_start_while_busy;
        run_dump(4'h0, 4'hF, 0, 5, 25, "restart");
    endtask

    task automatic test_mid_reset;
        bit seen_done;
        seen_done = 0;
        first_addr = 4'h0;
        last_addr  = 4'hF;
        m_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 6; c++) step();
        checks++;
        if (m_valid !== 1'b1 || m_addr !== 4'h3) begin
            errors++;
            $display("FAIL midrst_sendb: valid=%b addr=%h required 1 3", m_valid, m_addr);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || core_hold !== 1'b0 || done !== 1'b0 || rf_rs !== 4'h0) begin
            errors++;
            $display("FAIL midrst_outputs: valid=%b busy=%b hold=%b done=%b rs=%h required 0 0 0 0 0",
                     m_valid, busy, core_hold, done, rf_rs);
        end
        for (int c = 0; c < 6; c++) begin
            if (done === 1'b1 || m_valid === 1'b1) seen_done = 1;
            step();
        end
        checks++;
        if (seen_done) begin
            errors++;
            $display("FAIL midrst_quiet: activity after reset seen=1 required 0");
        end
        m_ready = 1'b0;
        run_dump(4'h0, 4'hF, 0, 0, 25, "post_rst");
    endtask

    initial begin
        test_reset();
        test_full_range();
        test_single();
        test_wrap();
        test_backpressure();
        test_mid_reset();
        test_start_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
